// File: rtl/Purple_Jade_pkg.sv
// rtl/Purple_Jade_pkg.sv - shared execute-stage types, opcodes and flag indices
package Purple_Jade_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int ROB_ENTRY    = 16;
  localparam int NUM_PHYS_REG = 64;
  localparam int ROB_TAG_W    = $clog2(ROB_ENTRY);
  localparam int REG_TAG_W    = $clog2(NUM_PHYS_REG);

  // Four opcode bits leave encodings 8..15 unused; they complete as zero results.
  localparam int WIDTH_OP = 4;
  localparam logic [WIDTH_OP-1:0] ADD_OP  = 4'd0;
  localparam logic [WIDTH_OP-1:0] SUB_OP  = 4'd1;
  localparam logic [WIDTH_OP-1:0] AND_OP  = 4'd2;
  localparam logic [WIDTH_OP-1:0] OR_OP   = 4'd3;
  localparam logic [WIDTH_OP-1:0] XOR_OP  = 4'd4;
  localparam logic [WIDTH_OP-1:0] SHL_OP  = 4'd5;
  localparam logic [WIDTH_OP-1:0] SHR_OP  = 4'd6;
  localparam logic [WIDTH_OP-1:0] PASS_OP = 4'd7;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_V    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;

  typedef struct packed {
    logic                 valid;
    logic [REG_TAG_W-1:0] dest;
    logic [NUM_FLAGS-1:0] flags;
    logic [WORD_SIZE-1:0] result;
  } CDB_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_dest;
    CDB_t                 cdb;
  } rob_wb_t;

  typedef struct packed {
    logic w_v;
    CDB_t cdb;
  } reg_wb_t;

  typedef struct packed {
    logic                 valid;
    logic                 w_v;
    logic [ROB_TAG_W-1:0] rob_dest;
    logic [REG_TAG_W-1:0] dest;
    logic [NUM_FLAGS-1:0] flags;
    logic [WORD_SIZE-1:0] result;
  } alu_stage_t;

  localparam int CDB_WIDTH    = $bits(CDB_t);
  localparam int ROB_WB_WIDTH = $bits(rob_wb_t);
  localparam int REG_WB_WIDTH = $bits(reg_wb_t);

endpackage

// File: rtl/fu_alu_pipe_alu_core.sv
// rtl/fu_alu_pipe_alu_core.sv - combinational ALU result and NZCV flags
module alu_core
  import Purple_Jade_pkg::*;
#(
  parameter int WORD_SIZE_P = 16
) (
  input  logic [WIDTH_OP-1:0]    opcode,
  input  logic [WORD_SIZE_P-1:0] a,
  input  logic [WORD_SIZE_P-1:0] b,
  output logic [WORD_SIZE_P-1:0] result,
  output logic [NUM_FLAGS-1:0]   flags
);

  localparam int W       = WORD_SIZE_P;
  localparam int SHAMT_W = $clog2(WORD_SIZE_P);

  logic [W:0]         sum;
  logic [W:0]         diff;
  logic [SHAMT_W-1:0] shamt;
  logic               known;
  logic               carry;
  logic               ovf;

  // The extra top bit of diff is the unsigned borrow (set exactly when a < b).
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHAMT_W-1:0];

  // Opcode decode; unknown opcodes leave result and all flags at zero.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    known  = 1'b1;
    case (opcode)
      ADD_OP: begin
        result = sum[W-1:0];
        carry  = sum[W];
        ovf    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      SUB_OP: begin
        result = diff[W-1:0];
        carry  = diff[W];
        ovf    = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      AND_OP:  result = a & b;
      OR_OP:   result = a | b;
      XOR_OP:  result = a ^ b;
      SHL_OP:  result = a << shamt;
      SHR_OP:  result = a >> shamt;
      PASS_OP: result = a;
      default: known = 1'b0;
    endcase
    flags = '0;
    if (known) begin
      flags[FLAG_N] = result[W-1];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
    end
  end

endmodule

// File: rtl/fu_alu_pipe.sv
// rtl/fu_alu_pipe.sv - pipelined ALU unit with backpressure, flush, optional FU_ALU_PIPE_PERF_EN counters
module fu_alu_pipe
  import Purple_Jade_pkg::*;
#(
  parameter int WORD_SIZE_P  = 16,
  parameter int NUM_STAGES_P = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    exe_v_i,
  input  logic                    w_v_i,
  input  logic [WIDTH_OP-1:0]     opcode_i,
  input  logic [WORD_SIZE_P-1:0]  operand1_i,
  input  logic [WORD_SIZE_P-1:0]  operand2_i,
  input  logic [ROB_TAG_W-1:0]    rob_dest_i,
  input  logic [REG_TAG_W-1:0]    reg_dest_i,
  input  logic                    flush_i,
  output logic                    ready_o,
  input  logic                    wb_ready_i,
  output logic [ROB_WB_WIDTH-1:0] alu_rob_o,
  output logic [REG_WB_WIDTH-1:0] alu_reg_o,
  output logic [CDB_WIDTH-1:0]    cdb_o,
  output logic [31:0]             perf_ops_o,
  output logic [31:0]             perf_stall_o
);

  localparam int LAST = NUM_STAGES_P - 1;

  alu_stage_t               stage_q [NUM_STAGES_P];
  alu_stage_t               stage_d [NUM_STAGES_P];
  // move[k]: stage k takes new contents at the next edge; move[NUM_STAGES_P] is the consumer.
  logic [NUM_STAGES_P:0]    move;
  logic [WORD_SIZE_P-1:0]   core_result;
  logic [NUM_FLAGS-1:0]     core_flags;
  alu_stage_t               issue_entry;
  alu_stage_t               last;

  alu_core #(
    .WORD_SIZE_P(WORD_SIZE_P)
  ) u_alu_core (
    .opcode(opcode_i),
    .a     (operand1_i),
    .b     (operand2_i),
    .result(core_result),
    .flags (core_flags)
  );

  // Result is produced at issue; only the tags and result travel down the pipe.
  always_comb begin
    issue_entry          = '0;
    issue_entry.valid    = exe_v_i & ~flush_i;
    issue_entry.w_v      = w_v_i;
    issue_entry.rob_dest = rob_dest_i;
    issue_entry.dest     = reg_dest_i;
    issue_entry.flags    = core_flags;
    issue_entry.result   = core_result;
  end

  assign move[NUM_STAGES_P] = wb_ready_i;
  assign ready_o            = move[0];

  for (genvar k = 0; k < NUM_STAGES_P; k++) begin : g_stage
    alu_stage_t src;
    alu_stage_t nxt;

    // An empty stage always refills, so bubbles collapse toward the output.
    assign move[k] = ~stage_q[k].valid | move[k+1];

    if (k == 0) begin : g_first
      assign src = issue_entry;
    end else begin : g_next
      assign src = stage_q[k-1];
    end

    // Flush kills the entry in place even when the stage is stalled.
    always_comb begin
      nxt = stage_q[k];
      if (flush_i) begin
        nxt.valid = 1'b0;
      end else if (move[k]) begin
        nxt = src;
      end
    end

    assign stage_d[k] = nxt;
  end

  // Pipeline register bank for all stages.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign last = stage_q[LAST];

  // Output formatting; everything reads zero while the last stage is empty.
  always_comb begin
    rob_wb_t rob_w;
    reg_wb_t reg_w;
    CDB_t    cdb_w;
    rob_w = '0;
    reg_w = '0;
    cdb_w = '0;
    if (last.valid) begin
      rob_w.rob_dest   = last.rob_dest;
      rob_w.cdb.valid  = 1'b1;
      rob_w.cdb.dest   = last.dest;
      rob_w.cdb.flags  = last.flags;
      rob_w.cdb.result = last.result;
      cdb_w            = rob_w.cdb;
      cdb_w.valid      = last.w_v;
      reg_w.w_v        = last.w_v;
      reg_w.cdb        = cdb_w;
    end
    alu_rob_o = rob_w;
    alu_reg_o = reg_w;
    cdb_o     = cdb_w;
  end

`ifdef FU_ALU_PIPE_PERF_EN
  logic [31:0] ops_q;
  logic [31:0] stall_q;

  // Handoff and output-stall counters; they wrap and only reset clears them.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (last.valid & wb_ready_i) begin
        ops_q <= ops_q + 32'd1;
      end
      if (last.valid & ~wb_ready_i) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_ops_o   = ops_q;
  assign perf_stall_o = stall_q;
`else
  assign perf_ops_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_fu_alu_pipe.sv
// tb/tb_fu_alu_pipe.sv - self-checking bench for fu_alu_pipe against a queue-based reference model
module tb_fu_alu_pipe;
  import Purple_Jade_pkg::*;

  localparam int N = 2;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset_n;
  logic                    exe_v;
  logic                    w_v;
  logic [WIDTH_OP-1:0]     opcode;
  logic [W-1:0]            op1;
  logic [W-1:0]            op2;
  logic [ROB_TAG_W-1:0]    rob_dest;
  logic [REG_TAG_W-1:0]    reg_dest;
  logic                    flush;
  logic                    ready;
  logic                    wb_ready;
  logic [ROB_WB_WIDTH-1:0] alu_rob;
  logic [REG_WB_WIDTH-1:0] alu_reg;
  logic [CDB_WIDTH-1:0]    cdb;
  logic [31:0]             perf_ops;
  logic [31:0]             perf_stall;

  rob_wb_t rob_s;
  reg_wb_t reg_s;
  CDB_t    cdb_s;
  assign rob_s = alu_rob;
  assign reg_s = alu_reg;
  assign cdb_s = cdb;

  fu_alu_pipe #(
    .WORD_SIZE_P (W),
    .NUM_STAGES_P(N)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .exe_v_i     (exe_v),
    .w_v_i       (w_v),
    .opcode_i    (opcode),
    .operand1_i  (op1),
    .operand2_i  (op2),
    .rob_dest_i  (rob_dest),
    .reg_dest_i  (reg_dest),
    .flush_i     (flush),
    .ready_o     (ready),
    .wb_ready_i  (wb_ready),
    .alu_rob_o   (alu_rob),
    .alu_reg_o   (alu_reg),
    .cdb_o       (cdb),
    .perf_ops_o  (perf_ops),
    .perf_stall_o(perf_stall)
  );

  typedef struct {
    rob_wb_t rob;
    reg_wb_t regw;
    CDB_t    cdb;
    int      age;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_ops = 0;
  int   m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on plain integers: returns {N,Z,C,V,result}.
  function automatic logic [19:0] ref_alu(input logic [3:0] op, input int a, input int b);
    int r, sa, sb, sr;
    bit c, v, n, z, known;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    r = 0; c = 0; v = 0; known = 1;
    case (op)
      ADD_OP: begin r = a + b; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      SUB_OP: begin r = a - b; c = (a < b); sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      AND_OP:  r = a & b;
      OR_OP:   r = a | b;
      XOR_OP:  r = a ^ b;
      SHL_OP:  r = a << (b % 16);
      SHR_OP:  r = a >> (b % 16);
      PASS_OP: r = a;
      default: known = 0;
    endcase
    r = r & 65535;
    n = known && (r >= 32768);
    z = known && (r == 0);
    return {n, z, c, v, r[15:0]};
  endfunction

  function automatic exp_t make_exp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic wv, input logic [ROB_TAG_W-1:0] rb,
                                    input logic [REG_TAG_W-1:0] rg);
    exp_t x;
    logic [19:0] fr;
    fr = ref_alu(op, int'(a), int'(b));
    x.rob.rob_dest   = rb;
    x.rob.cdb.valid  = 1'b1;
    x.rob.cdb.dest   = rg;
    x.rob.cdb.flags  = fr[19:16];
    x.rob.cdb.result = fr[15:0];
    x.cdb            = x.rob.cdb;
    x.cdb.valid      = wv;
    x.regw.w_v       = wv;
    x.regw.cdb       = x.cdb;
    x.age            = 0;
    return x;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input logic e, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic wv, input logic [ROB_TAG_W-1:0] rb, input logic [REG_TAG_W-1:0] rg,
                     input logic fl, input logic wr, output logic acc);
    bit exp_valid, m_ready;
    exe_v = e; opcode = op; op1 = a; op2 = b; w_v = wv; rob_dest = rb; reg_dest = rg;
    flush = fl; wb_ready = wr;
    #1;
    m_ready   = (q.size() < N) || wr;
    exp_valid = (q.size() > 0) && (q[0].age >= N - 1);
    chk("ready", ready, m_ready);
    if (exp_valid) begin
      chk("rob_out", alu_rob, q[0].rob);
      chk("reg_out", alu_reg, q[0].regw);
      chk("cdb_out", cdb, q[0].cdb);
    end else begin
      chk("rob_idle", alu_rob, 0);
      chk("reg_idle", alu_reg, 0);
      chk("cdb_idle", cdb, 0);
    end
    acc = e && m_ready && !fl;
    @(posedge clk);
    if (exp_valid && wr) m_ops++;
    if (exp_valid && !wr) m_stall++;
    if (fl) begin
      q.delete();
    end else begin
      if (exp_valid && wr) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (acc) q.push_back(make_exp(op, a, b, wv, rb, rg));
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic wv,
                       input logic [ROB_TAG_W-1:0] rb, input logic [REG_TAG_W-1:0] rg, input logic wr);
    logic acc;
    int n;
    n = 0;
    do begin
      cyc(1'b1, op, a, b, wv, rb, rg, 1'b0, wr, acc);
      n++;
    end while (!acc && n < 20);
    chk("issue_accept", acc, 1);
  endtask

  task automatic idle(input logic wr, input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) cyc(1'b0, 4'd0, 16'd0, 16'd0, 1'b0, '0, '0, 1'b0, wr, acc);
  endtask

  task automatic perf_chk(input string tag);
`ifdef FU_ALU_PIPE_PERF_EN
    chk({tag, "_ops"}, perf_ops, 64'(m_ops));
    chk({tag, "_stall"}, perf_stall, 64'(m_stall));
`else
    chk({tag, "_ops_tied"}, perf_ops, 0);
    chk({tag, "_stall_tied"}, perf_stall, 0);
`endif
  endtask

  initial begin
    logic acc;
    int   stall_base;
    reset_n = 1'b0; exe_v = 0; w_v = 0; opcode = '0; op1 = '0; op2 = '0;
    rob_dest = '0; reg_dest = '0; flush = 0; wb_ready = 0;
    @(negedge clk);
    #1;
    chk("reset_rob", alu_rob, 0);
    chk("reset_reg", alu_reg, 0);
    chk("reset_cdb", cdb, 0);
    chk("reset_perf_ops", perf_ops, 0);
    chk("reset_perf_stall", perf_stall, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ADD overflow into the sign bit, visible two cycles after issue.
    cyc(1'b1, ADD_OP, 16'h7FFF, 16'h0001, 1'b1, 4'd3, 6'd9, 1'b0, 1'b1, acc);
    idle(1'b1, 1);
    #1;
    chk("t1_cdb", cdb, {1'b1, 6'd9, 4'b1001, 16'h8000});
    chk("t1_rob_dest", rob_s.rob_dest, 4'd3);

    // SUB zero, SUB borrow, SHL with the amount taken modulo width.
    issue(SUB_OP, 16'h0005, 16'h0005, 1'b1, 4'd4, 6'd10, 1'b1);
    issue(SUB_OP, 16'h0003, 16'h0005, 1'b1, 4'd5, 6'd11, 1'b1);
    #1;
    chk("t2_sub_zero", cdb, {1'b1, 6'd10, 4'b0100, 16'h0000});
    issue(SHL_OP, 16'h0001, 16'h0013, 1'b1, 4'd6, 6'd12, 1'b1);
    #1;
    chk("t2_sub_borrow", cdb, {1'b1, 6'd11, 4'b1010, 16'hFFFE});
    issue(ADD_OP, 16'hFFFF, 16'h0001, 1'b1, 4'd7, 6'd13, 1'b1);
    #1;
    chk("t2_shl", cdb, {1'b1, 6'd12, 4'b0000, 16'h0008});
    idle(1'b1, 1);
    #1;
    chk("t2_add_carry", cdb, {1'b1, 6'd13, 4'b0110, 16'h0000});

    // Non-writing op still retires to the ROB.
    issue(XOR_OP, 16'h00F0, 16'h0F00, 1'b0, 4'd8, 6'd14, 1'b1);
    idle(1'b1, 1);
    #1;
    chk("t4_rob_valid", rob_s.cdb.valid, 1);
    chk("t4_reg_wv", reg_s.w_v, 0);
    chk("t4_cdb_valid", cdb_s.valid, 0);
    idle(1'b1, 1);

    // Backpressure: fill the pipe, stall four cycles, then release.
    stall_base = m_stall;
    issue(OR_OP, 16'h1200, 16'h0034, 1'b1, 4'd1, 6'd1, 1'b0);
    issue(AND_OP, 16'hFF0F, 16'h0FF0, 1'b1, 4'd2, 6'd2, 1'b0);
    cyc(1'b1, PASS_OP, 16'hABCD, 16'h0000, 1'b1, 4'd3, 6'd3, 1'b0, 1'b0, acc);
    #1;
    chk("t3_ready_full", ready, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, PASS_OP, 16'hABCD, 16'h0000, 1'b1, 4'd3, 6'd3, 1'b0, 1'b0, acc);
    cyc(1'b1, PASS_OP, 16'hABCD, 16'h0000, 1'b1, 4'd3, 6'd3, 1'b0, 1'b1, acc);
    chk("t3_accept_on_release", acc, 1);
    idle(1'b1, 3);
    chk("t3_stall_cycles", 64'(m_stall - stall_base), 4);
    perf_chk("t3_perf");

    // Flush two in-flight ops plus a same-cycle issue.
    issue(ADD_OP, 16'h0001, 16'h0002, 1'b1, 4'd9, 6'd20, 1'b0);
    issue(ADD_OP, 16'h0003, 16'h0004, 1'b1, 4'd10, 6'd21, 1'b0);
    cyc(1'b1, ADD_OP, 16'h0005, 16'h0006, 1'b1, 4'd11, 6'd22, 1'b1, 1'b0, acc);
    idle(1'b1, 4);
    issue(SHR_OP, 16'h8000, 16'h000F, 1'b1, 4'd12, 6'd23, 1'b1);
    idle(1'b1, 1);
    #1;
    chk("t5_after_flush", cdb, {1'b1, 6'd23, 4'b0000, 16'h0001});
    idle(1'b1, 1);

    // Asynchronous reset in the middle of a stall.
    issue(ADD_OP, 16'h1111, 16'h2222, 1'b1, 4'd13, 6'd30, 1'b0);
    issue(SUB_OP, 16'h3333, 16'h1111, 1'b1, 4'd14, 6'd31, 1'b0);
    idle(1'b0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rob_zero", alu_rob, 0);
    chk("t6_reg_zero", alu_reg, 0);
    chk("t6_cdb_zero", cdb, 0);
    q.delete();
    m_ops = 0;
    m_stall = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t6_ready_after", ready, 1);
    perf_chk("t6_perf");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
          1'($urandom), 4'($urandom), 6'($urandom), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 9) < 6), acc);
    end
    idle(1'b1, 5);
    chk("drain_empty", 64'(q.size()), 0);
    perf_chk("final_perf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
